// File: rtl/proc_rst_pkg.sv
// Shared types, default parameters and helpers for the multi-core reset sequencer.
package proc_rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_HALT
    } state_t;

    localparam int unsigned NUM_CORES_DEF   = 4;
    localparam int unsigned HOLD_CYCLES_DEF = 16;
    localparam int unsigned STAGGER_DEF     = 2;
    localparam int unsigned CYC_W_DEF       = 32;
    localparam int unsigned MAX_RETRY_DEF   = 3;

    // Width of a core index; never narrower than one bit.
    function automatic int unsigned CORE_IDX_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset, clear and enable.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/proc_rst_seq.sv
// Multi-core reset sequencer with staggered release and first-error recording.
// Optional per-core local restart is enabled by defining PROC_RST_SEQ_AUTORESTART_EN.
module proc_rst_seq
    import proc_rst_pkg::*;
#(
    parameter int unsigned NUM_CORES   = NUM_CORES_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned STAGGER     = STAGGER_DEF,
`ifdef PROC_RST_SEQ_AUTORESTART_EN
    parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF,
`endif
    parameter int unsigned CYC_W       = CYC_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CORES-1:0]                err,
    input  logic                                err_clr,
    output logic [NUM_CORES-1:0]                core_rst,
    output logic                                running,
    output logic                                halted,
    output logic                                err_valid,
    output logic [CORE_IDX_W(NUM_CORES)-1:0]    err_core,
    output logic [CYC_W-1:0]                    err_cycle
);

    localparam int unsigned IW = CORE_IDX_W(NUM_CORES);
    localparam int unsigned SW = $clog2(((HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER) + 1);

    state_t               state;
    logic [SW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [CYC_W-1:0]     cyc;
    logic [NUM_CORES-1:0] hon_c;
    logic [IW-1:0]        first_c;
    logic                 halt_c;

    sat_counter #(.W(CYC_W)) u_cyc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (1'b1),
        .q     (cyc)
    );

    // A core's error only counts once that core is out of reset.
    assign hon_c = ((state == ST_RELEASE) || (state == ST_RUN)) ? (err & ~core_rst) : '0;

    always_comb begin
        first_c = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hon_c[i]) first_c = IW'(i);
        end
    end

`ifdef PROC_RST_SEQ_AUTORESTART_EN
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    logic [NUM_CORES-1:0][RW-1:0] retry;
    logic [NUM_CORES-1:0]         lr_act;
    logic [NUM_CORES-1:0]         lr_done_c;
    logic [NUM_CORES-1:0]         fatal_c;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_lr
        logic [HW-1:0] hcnt;

        sat_counter #(.W(HW)) u_hold (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (hon_c[g]),
            .en    (lr_act[g]),
            .q     (hcnt)
        );

        assign lr_done_c[g] = lr_act[g] && (hcnt == HW'(HOLD_CYCLES - 1));
        assign fatal_c[g]   = hon_c[g] && (retry[g] == RW'(MAX_RETRY));
    end

    assign halt_c = |fatal_c;
`else
    assign halt_c = |hon_c;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_HOLD;
            cnt       <= '0;
            idx       <= '0;
            core_rst  <= '1;
            running   <= 1'b0;
            halted    <= 1'b0;
            err_valid <= 1'b0;
            err_core  <= '0;
            err_cycle <= '0;
`ifdef PROC_RST_SEQ_AUTORESTART_EN
            lr_act    <= '0;
            retry     <= '0;
`endif
        end else begin
            if ((|hon_c) && !err_valid) begin
                err_valid <= 1'b1;
                err_core  <= first_c;
                err_cycle <= cyc;
            end

            case (state)
                ST_HOLD: begin
                    if (cnt == SW'(HOLD_CYCLES - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + SW'(1);
                    end
                end

                ST_RELEASE, ST_RUN: begin
                    if (halt_c) begin
                        state    <= ST_HALT;
                        core_rst <= '1;
                        running  <= 1'b0;
                        halted   <= 1'b1;
`ifdef PROC_RST_SEQ_AUTORESTART_EN
                        lr_act   <= '0;
`endif
                    end else begin
                        // Release one core, then count STAGGER-1 idle clocks.
                        if (state == ST_RELEASE) begin
                            if (cnt == '0) begin
                                core_rst[idx] <= 1'b0;
                                cnt           <= SW'(STAGGER - 1);
                                if (idx == IW'(NUM_CORES - 1)) begin
                                    state   <= ST_RUN;
                                    running <= 1'b1;
                                end else begin
                                    idx <= idx + IW'(1);
                                end
                            end else begin
                                cnt <= cnt - SW'(1);
                            end
                        end
`ifdef PROC_RST_SEQ_AUTORESTART_EN
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (hon_c[i]) begin
                                core_rst[i] <= 1'b1;
                                lr_act[i]   <= 1'b1;
                                retry[i]    <= retry[i] + RW'(1);
                            end else if (lr_done_c[i]) begin
                                core_rst[i] <= 1'b0;
                                lr_act[i]   <= 1'b0;
                            end
                        end
`endif
                    end
                end

                ST_HALT: begin
                    if (err_clr) begin
                        err_valid <= 1'b0;
                        err_core  <= '0;
                        err_cycle <= '0;
                        halted    <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_HOLD;
                    end
                end

                default: state <= ST_HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_rst_seq.sv
// Self-checking bench for proc_rst_seq: release-timing table plus error-record scoreboard.
module tb_proc_rst_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  err;
    logic        err_clr;
    logic [3:0]  core_rst;
    logic        running;
    logic        halted;
    logic        err_valid;
    logic [1:0]  err_core;
    logic [31:0] err_cycle;

    typedef struct {
        logic [3:0] err;
        logic [3:0] rst;
        logic       run;
    } rel_t;

    typedef struct {
        logic [1:0]  core;
        logic [31:0] cyc;
    } rec_t;

    rel_t        rel_tab[16];
    rec_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cyc_m = 0;
    logic [31:0] first_cyc;

    always #5 clk = ~clk;

    proc_rst_seq #(
        .NUM_CORES   (4),
        .HOLD_CYCLES (8),
        .STAGGER     (2),
`ifdef PROC_RST_SEQ_AUTORESTART_EN
        .MAX_RETRY   (2),
`endif
        .CYC_W       (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .err       (err),
        .err_clr   (err_clr),
        .core_rst  (core_rst),
        .running   (running),
        .halted    (halted),
        .err_valid (err_valid),
        .err_core  (err_core),
        .err_cycle (err_cycle)
    );

    // One clock; tracks the expected cycle counter value after the edge.
    task automatic tick;
        @(posedge clk);
        if (rst_n) begin
            if (cyc_m != 32'hFFFF_FFFF) cyc_m = cyc_m + 1;
        end else begin
            cyc_m = 0;
        end
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_record(input string name);
        rec_t r;
        int   k = 0;
        while (!err_valid && k < 4) begin
            tick;
            k++;
        end
        if (!err_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: err_valid got 0 expected 1", name);
        end else if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_empty: got record expected none queued", name);
        end else begin
            r = sb.pop_front();
            check({name, "_core"}, 32'(err_core), 32'(r.core));
            check({name, "_cycle"}, err_cycle, r.cyc);
        end
    endtask

    task automatic run_release(input string name);
        for (int k = 0; k < 16; k++) begin
            err = rel_tab[k].err;
            tick;
            check($sformatf("%s_rst_e%0d", name, k + 1), 32'(core_rst), 32'(rel_tab[k].rst));
            check($sformatf("%s_run_e%0d", name, k + 1), 32'(running), 32'(rel_tab[k].run));
            check($sformatf("%s_ev_e%0d", name, k + 1), 32'(err_valid), 32'd0);
        end
        err = 4'b0000;
    endtask

    task automatic apply_reset;
        rst_n   = 1'b0;
        err     = 4'b0000;
        err_clr = 1'b0;
        repeat (3) tick;
        check("rst_core_rst", 32'(core_rst), 32'hF);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err_core", 32'(err_core), 32'd0);
        check("rst_err_cycle", err_cycle, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // err[3] is held high from edge 9 to 15 while core 3 is still in reset.
        for (int k = 0; k < 8; k++) rel_tab[k] = '{4'b0000, 4'b1111, 1'b0};
        rel_tab[8]  = '{4'b1000, 4'b1110, 1'b0};
        rel_tab[9]  = '{4'b1000, 4'b1110, 1'b0};
        rel_tab[10] = '{4'b1000, 4'b1100, 1'b0};
        rel_tab[11] = '{4'b1000, 4'b1100, 1'b0};
        rel_tab[12] = '{4'b1000, 4'b1000, 1'b0};
        rel_tab[13] = '{4'b1000, 4'b1000, 1'b0};
        rel_tab[14] = '{4'b1000, 4'b0000, 1'b1};
        rel_tab[15] = '{4'b0000, 4'b0000, 1'b1};

        apply_reset();
        run_release("seq1");

`ifdef PROC_RST_SEQ_AUTORESTART_EN
        for (int r = 0; r < 3; r++) begin
            err = 4'b0010;
            if (r == 0) begin
                first_cyc = cyc_m;
                sb.push_back('{2'd1, cyc_m});
            end
            tick;
            err = 4'b0000;
            check($sformatf("lr%0d_err_valid", r), 32'(err_valid), 32'd1);
            if (r < 2) begin
                check($sformatf("lr%0d_assert", r), 32'(core_rst), 32'h2);
                check($sformatf("lr%0d_running", r), 32'(running), 32'd1);
                check($sformatf("lr%0d_halted", r), 32'(halted), 32'd0);
                for (int c = 0; c < 7; c++) begin
                    tick;
                    check($sformatf("lr%0d_hold_%0d", r, c), 32'(core_rst), 32'h2);
                end
                tick;
                check($sformatf("lr%0d_release", r), 32'(core_rst), 32'h0);
            end else begin
                check("lr_final_rst", 32'(core_rst), 32'hF);
                check("lr_final_halted", 32'(halted), 32'd1);
                check("lr_final_running", 32'(running), 32'd0);
            end
            if (r == 0) pop_record("lr_rec");
        end
        check("lr_rec_core_kept", 32'(err_core), 32'd1);
        check("lr_rec_cycle_kept", err_cycle, first_cyc);
`else
        // Single error in RUN at cycle counter 40.
        while (cyc_m < 40) tick;
        err = 4'b0100;
        sb.push_back('{2'd2, cyc_m});
        tick;
        err = 4'b0000;
        check("run_err_valid_lat", 32'(err_valid), 32'd1);
        check("run_err_core_rst", 32'(core_rst), 32'hF);
        check("run_err_halted", 32'(halted), 32'd1);
        check("run_err_running", 32'(running), 32'd0);
        pop_record("run_err");

        // Clear from HALT and resequence with identical timing.
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("clr_err_valid", 32'(err_valid), 32'd0);
        check("clr_err_core", 32'(err_core), 32'd0);
        check("clr_err_cycle", err_cycle, 32'd0);
        check("clr_halted", 32'(halted), 32'd0);
        check("clr_core_rst", 32'(core_rst), 32'hF);
        run_release("seq2");

        // Two simultaneous errors plus err_clr in RUN: lowest index wins, clear ignored.
        repeat (3) tick;
        err     = 4'b1010;
        err_clr = 1'b1;
        sb.push_back('{2'd1, cyc_m});
        tick;
        err     = 4'b0001;
        err_clr = 1'b0;
        check("sim_err_valid", 32'(err_valid), 32'd1);
        check("sim_halted", 32'(halted), 32'd1);
        tick;
        err = 4'b0000;
        check("sim_still_valid", 32'(err_valid), 32'd1);
        pop_record("sim_err");

        // rst_n in HALT wipes the record.
        rst_n = 1'b0;
        tick;
        check("hrst_err_valid", 32'(err_valid), 32'd0);
        check("hrst_err_cycle", err_cycle, 32'd0);
        check("hrst_halted", 32'(halted), 32'd0);
        check("hrst_core_rst", 32'(core_rst), 32'hF);
        rst_n = 1'b1;

        // rst_n mid-RELEASE forces all cores back into reset next clock.
        repeat (10) tick;
        check("mid_rel_rst", 32'(core_rst), 32'hE);
        check("mid_rel_running", 32'(running), 32'd0);
        rst_n = 1'b0;
        tick;
        check("mid_rst_core_rst", 32'(core_rst), 32'hF);
        rst_n = 1'b1;
        repeat (3) tick;
        check("mid_rst_hold", 32'(core_rst), 32'hF);
`endif

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
